// File: rtl/test_status_monitor.sv
`default_nettype none
// ============================================================================
// Module      : test_status_monitor
// Description : Snoops register-file writebacks and declares a sticky
//               PASS/FAIL/TIMEOUT verdict from the signature register.
// Revision    : 1.0 - initial release
// ============================================================================
module test_status_monitor #(
    parameter int unsigned               NUM_WB         = 1,
    parameter int unsigned               DATA_WIDTH     = 32,
    parameter int unsigned               REG_ADDR_WIDTH = 5,
    parameter int unsigned               SIG_REG        = 17,
    parameter int unsigned               ARG_REG        = 10,
    parameter logic [DATA_WIDTH-1:0]     PASS_CODE      = 32'h0D000721,
    parameter logic [DATA_WIDTH-1:0]     FAIL_CODE      = 32'h01919810,
    parameter int unsigned               HOLD_CYCLES    = 3,
    parameter int unsigned               TIMEOUT_CYCLES = 10000,
    parameter int unsigned               CNT_WIDTH      = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic [NUM_WB-1:0]                wb_en,
    input  logic [NUM_WB*REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [NUM_WB*DATA_WIDTH-1:0]     wb_data,
    output logic                             done,
    output logic                             pass,
    output logic                             fail,
    output logic                             timeout,
    output logic [DATA_WIDTH-1:0]            fail_id,
    output logic [CNT_WIDTH-1:0]             cycle_count
);

    localparam int unsigned HW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

    localparam logic [2:0] ST_RUN     = 3'd0;
    localparam logic [2:0] ST_ARMED   = 3'd1;
    localparam logic [2:0] ST_PASS    = 3'd2;
    localparam logic [2:0] ST_FAIL    = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;

    localparam logic [REG_ADDR_WIDTH-1:0] SIG_IDX  = REG_ADDR_WIDTH'(SIG_REG);
    localparam logic [REG_ADDR_WIDTH-1:0] ARG_IDX  = REG_ADDR_WIDTH'(ARG_REG);
    localparam logic [HW-1:0]             HOLD_LIM = HW'(HOLD_CYCLES);
    localparam logic [CNT_WIDTH-1:0]      TO_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [2:0]            state_q,   state_d;
    logic [DATA_WIDTH-1:0] sig_q,     sig_d;
    logic [DATA_WIDTH-1:0] arg_q,     arg_d;
    logic [DATA_WIDTH-1:0] cand_q,    cand_d;
    logic [HW-1:0]         hold_q,    hold_d;
    logic [CNT_WIDTH-1:0]  cnt_q,     cnt_d;
    logic                  pass_q,    pass_d;
    logic                  fail_q,    fail_d;
    logic                  timeout_q, timeout_d;
    logic [DATA_WIDTH-1:0] id_q,      id_d;

    logic                  code_hit;
    logic                  verdict;
    logic [HW-1:0]         hold_nxt;
    logic [REG_ADDR_WIDTH-1:0] port_rd;

    always_comb begin
        sig_d     = sig_q;
        arg_d     = arg_q;
        state_d   = state_q;
        cand_d    = cand_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        id_d      = id_q;
        verdict   = 1'b0;
        hold_nxt  = '0;
        port_rd   = '0;
        code_hit  = (sig_q == PASS_CODE) || (sig_q == FAIL_CODE);

        // Ascending port order lets the highest-numbered port win a collision.
        for (int p = 0; p < int'(NUM_WB); p++) begin
            port_rd = wb_rd[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            if (wb_en[p] && (port_rd != '0)) begin
                if (port_rd == SIG_IDX) sig_d = wb_data[p*DATA_WIDTH +: DATA_WIDTH];
                if (port_rd == ARG_IDX) arg_d = wb_data[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        if ((state_q == ST_RUN) || (state_q == ST_ARMED)) begin
            if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);

            if (code_hit) begin
                // hold_nxt counts cycles the code has been held, this one included.
                hold_nxt = ((state_q == ST_ARMED) && (sig_q == cand_q)) ?
                           hold_q + HW'(1) : HW'(1);
                if (hold_nxt >= HOLD_LIM) begin
                    verdict = 1'b1;
                    id_d    = arg_q;
                    hold_d  = '0;
                    if (sig_q == PASS_CODE) begin
                        state_d = ST_PASS;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = ST_FAIL;
                        fail_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_ARMED;
                    cand_d  = sig_q;
                    hold_d  = hold_nxt;
                end
            end else begin
                state_d = ST_RUN;
                hold_d  = '0;
            end

            if (!verdict && (cnt_q == TO_LAST)) begin
                state_d   = ST_TIMEOUT;
                timeout_d = 1'b1;
            end
        end

        if (clear) begin
            sig_d     = '0;
            arg_d     = '0;
            state_d   = ST_RUN;
            cand_d    = '0;
            hold_d    = '0;
            cnt_d     = '0;
            pass_d    = 1'b0;
            fail_d    = 1'b0;
            timeout_d = 1'b0;
            id_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            sig_q     <= '0;
            arg_q     <= '0;
            cand_q    <= '0;
            hold_q    <= '0;
            cnt_q     <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            sig_q     <= sig_d;
            arg_q     <= arg_d;
            cand_q    <= cand_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
            id_q      <= id_d;
        end
    end

    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign done        = pass_q | fail_q | timeout_q;
    assign fail_id     = id_q;
    assign cycle_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_test_status_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_test_status_monitor
// Description : Directed and randomized bench for test_status_monitor with a
//               history-window reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_test_status_monitor;

    localparam int          HOLD  = 3;
    localparam int          TOUT  = 50;
    localparam logic [31:0] PASSC = 32'h0D000721;
    localparam logic [31:0] FAILC = 32'h01919810;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [1:0]  wb_en;
    logic [9:0]  wb_rd;
    logic [63:0] wb_data;
    logic        done, pass, fail, timeout;
    logic [31:0] fail_id, cycle_count;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: shadow histories indexed by edge number since reset/clear.
    logic [31:0] m_sig[$];
    logic [31:0] m_arg[$];
    int          m_edge;
    bit          m_term;
    logic        m_pass, m_fail, m_to;
    logic [31:0] m_id, m_cnt;

    test_status_monitor #(
        .NUM_WB(2), .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .SIG_REG(17), .ARG_REG(10),
        .PASS_CODE(PASSC), .FAIL_CODE(FAILC), .HOLD_CYCLES(HOLD),
        .TIMEOUT_CYCLES(TOUT), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .fail_id(fail_id), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_sig.delete(); m_arg.delete();
        m_sig.push_back(32'h0); m_arg.push_back(32'h0);
        m_edge = 0; m_term = 0;
        m_pass = 0; m_fail = 0; m_to = 0; m_id = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input logic clr, input logic [1:0] en,
                              input logic [4:0] rd0, input logic [4:0] rd1,
                              input logic [31:0] d0, input logic [31:0] d1);
        int          n;
        bit          held;
        logic [31:0] c, s, a;
        logic [4:0]  rd [2];
        logic [31:0] d  [2];
        if (clr) begin
            model_reset();
            return;
        end
        if (m_term) return;
        n = m_edge + 1;
        m_cnt = n;
        held = 0;
        if (n >= HOLD) begin
            c = m_sig[n-1];
            held = (c == PASSC) || (c == FAILC);
            for (int k = 1; k <= HOLD; k++)
                if (m_sig[n-k] != c) held = 0;
        end
        if (held) begin
            m_term = 1;
            m_id   = m_arg[n-1];
            if (c == PASSC) m_pass = 1; else m_fail = 1;
        end else if (n == TOUT) begin
            m_term = 1;
            m_to   = 1;
        end
        m_edge = n;
        s = m_sig[$]; a = m_arg[$];
        rd[0] = rd0; rd[1] = rd1; d[0] = d0; d[1] = d1;
        for (int p = 0; p < 2; p++) begin
            if (en[p] && rd[p] == 5'd17) s = d[p];
            if (en[p] && rd[p] == 5'd10) a = d[p];
        end
        m_sig.push_back(s); m_arg.push_back(a);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, m_edge);
        end
    endtask

    task automatic check_all();
        chk("pass",        32'(pass),    32'(m_pass));
        chk("fail",        32'(fail),    32'(m_fail));
        chk("timeout",     32'(timeout), 32'(m_to));
        chk("done",        32'(done),    32'(m_pass | m_fail | m_to));
        chk("fail_id",     fail_id,      m_id);
        chk("cycle_count", cycle_count,  m_cnt);
    endtask

    task automatic step(input logic clr, input logic [1:0] en,
                        input logic [4:0] rd0, input logic [4:0] rd1,
                        input logic [31:0] d0, input logic [31:0] d1);
        @(negedge clk);
        clear = clr; wb_en = en; wb_rd = {rd1, rd0}; wb_data = {d1, d0};
        @(posedge clk);
        model_edge(clr, en, rd0, rd1, d0, d1);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic do_clear();
        step(1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    endtask

    function automatic logic [4:0] rnd_rd();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd10;
            2:       return 5'd17;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    function automatic logic [31:0] rnd_data();
        case ($urandom_range(0, 3))
            0:       return PASSC;
            1:       return FAILC;
            2:       return 32'($urandom);
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; clear = 1'b0; wb_en = '0; wb_rd = '0; wb_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        #1 rst_n = 1'b1;

        // Pass: x10=0 and x17=PASS together at edge 10.
        idle(9);
        step(1'b0, 2'b11, 5'd10, 5'd17, 32'h0, PASSC);
        idle(2);
        chk("t1_pass_early", 32'(pass), 32'd0);
        idle(1);
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_id",   fail_id,   32'd0);
        chk("t1_cnt",  cycle_count, 32'd13);

        // Fail with fail_id = 5.
        do_clear();
        idle(18);
        step(1'b0, 2'b01, 5'd10, 5'd0, 32'd5, 32'h0);
        step(1'b0, 2'b01, 5'd17, 5'd0, FAILC, 32'h0);
        idle(3);
        chk("t2_fail", 32'(fail), 32'd1);
        chk("t2_id",   fail_id,   32'd5);

        // Code withdrawn before the hold completes, then rewritten.
        do_clear();
        idle(9);
        step(1'b0, 2'b01, 5'd17, 5'd0, PASSC, 32'h0);
        idle(1);
        step(1'b0, 2'b01, 5'd17, 5'd0, 32'h0, 32'h0);
        idle(17);
        chk("t3_no_verdict", 32'(done), 32'd0);
        step(1'b0, 2'b01, 5'd17, 5'd0, PASSC, 32'h0);
        idle(3);
        chk("t3_pass", 32'(pass), 32'd1);
        chk("t3_cnt",  cycle_count, 32'd33);

        // Timeout with no writes; counter freezes at TOUT.
        do_clear();
        idle(TOUT);
        chk("t4_timeout", 32'(timeout), 32'd1);
        chk("t4_pass",    32'(pass | fail), 32'd0);
        idle(3);
        chk("t4_cnt_frozen", cycle_count, 32'(TOUT));

        // Verdict coincides with timeout edge: verdict wins.
        do_clear();
        idle(46);
        step(1'b0, 2'b01, 5'd17, 5'd0, PASSC, 32'h0);
        idle(3);
        chk("t5_pass",    32'(pass),    32'd1);
        chk("t5_timeout", 32'(timeout), 32'd0);

        // Same-cycle collision: port 1 wins; then clear.
        do_clear();
        idle(4);
        step(1'b0, 2'b11, 5'd17, 5'd17, FAILC, PASSC);
        idle(3);
        chk("t6_pass", 32'(pass), 32'd1);
        chk("t6_fail", 32'(fail), 32'd0);
        do_clear();
        chk("t6_clr_done", 32'(done), 32'd0);
        chk("t6_clr_cnt",  cycle_count, 32'd0);
        idle(1);
        chk("t6_restart_cnt", cycle_count, 32'd1);

        // Asynchronous reset while armed discards the hold.
        do_clear();
        idle(4);
        step(1'b0, 2'b01, 5'd17, 5'd0, PASSC, 32'h0);
        idle(1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle(6);
        chk("t7_no_verdict", 32'(done), 32'd0);

        // Randomized runs against the reference model.
        for (int run = 0; run < 8; run++) begin
            do_clear();
            for (int c = 0; c < 60; c++) begin
                if ($urandom_range(0, 9) < 4)
                    step(1'b0, 2'($urandom_range(0, 3)), rnd_rd(), rnd_rd(),
                         rnd_data(), rnd_data());
                else
                    idle(1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
